// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule expander.
// Takes one padded 512-bit block and streams W[0..63] to the round engine
// over a valid/ready handshake. Only a 16-word sliding window is stored:
// each accepted word shifts the window down and appends the next W[t+16].
module sha256_msg_schedule #(
    parameter int ROUNDS = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         block_valid,
    input  logic [511:0] message_vector,
    output logic         block_ready,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_data,
    output logic [5:0]   w_index,
    output logic         schedule_complete,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        DONE
    } state_t;

    localparam logic [5:0] LastIndex = 6'(ROUNDS - 1);

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_window [16];
    logic [5:0]  r_t;

    logic        w_load;
    logic        w_transfer;
    logic        w_lastWord;
    logic [31:0] w_newWord;

    // Small sigma functions of the schedule recurrence, written as rotations
    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign w_load     = (r_state == IDLE) && block_valid;
    assign w_transfer = (r_state == EMIT) && w_ready;
    assign w_lastWord = w_transfer && (r_t == LastIndex);

    // Next window word from pre-shift values: slots 14, 9, 1, 0 hold
    // W[t+14], W[t+9], W[t+1], W[t]; the sum wraps modulo 2^32
    assign w_newWord = sigma1(r_window[14]) + r_window[9] + sigma0(r_window[1]) + r_window[0];

    // Handshake outputs are decoded from registered state only; block_ready
    // is additionally gated by reset so it reads 0 while reset is held low
    assign block_ready       = (r_state == IDLE) && reset;
    assign w_valid           = (r_state == EMIT);
    assign busy              = (r_state != IDLE);
    assign schedule_complete = (r_state == DONE);
    assign w_data            = r_window[0];
    assign w_index           = r_t;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: load in IDLE, stream in EMIT, one DONE cycle after W[63]
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (block_valid) begin
                    w_nextState = EMIT;
                end
            end
            EMIT: begin
                if (w_lastWord) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Window and word counter: big-endian load, shift-and-append on each accepted word;
    // the counter wraps to 0 after W[63] so words generated past it are simply dropped
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                r_window[i] <= '0;
            end
            r_t <= '0;
        end else if (w_load) begin
            for (int i = 0; i < 16; i++) begin
                r_window[i] <= message_vector[511 - 32*i -: 32];
            end
            r_t <= '0;
        end else if (w_transfer) begin
            for (int i = 0; i < 15; i++) begin
                r_window[i] <= r_window[i + 1];
            end
            r_window[15] <= w_newWord;
            r_t          <= r_t + 6'd1;
        end
    end

endmodule
